// File: rtl/calc_sequencer.sv
// Valid/ready sequencer wrapped around a combinational calculator stage.
// Define CALC_SEQ_SAT_EN to saturate overflowing results instead of wrapping.
module calc_sequencer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic         cmd_use_acc,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic [2:0]   calc_op,
  output logic [W-1:0] calc_a,
  output logic [W-1:0] calc_b,
  input  logic [W-1:0] calc_r,
  input  logic         calc_ovf,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_ovf,
  output logic [W-1:0] acc,
  input  logic         acc_clr,
  output logic         ovf_sticky,
  input  logic         ovf_clr,
  output logic [15:0]  op_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  state_t         r_state;
  state_t         w_next;
  logic [2:0]     r_calc_op;
  logic [W-1:0]   r_calc_a;
  logic [W-1:0]   r_calc_b;
  logic [W-1:0]   r_res_data;
  logic           r_res_ovf;
  logic [W-1:0]   r_acc;
  logic           r_sticky;
  logic [15:0]    r_count;
  logic           w_accept;
  logic           w_exec;
  logic [W-1:0]   w_v;

  assign w_accept = cmd_valid && (r_state == IDLE);
  assign w_exec   = (r_state == EXEC);

`ifdef CALC_SEQ_SAT_EN
  // A negative-looking wrapped result means the true value overflowed upward.
  always_comb begin
    w_v = calc_r;
    if (calc_ovf) begin
      w_v = calc_r[W-1] ? SAT_MAX : SAT_MIN;
    end
  end
`else
  always_comb begin
    w_v = calc_r;
  end
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (cmd_valid) w_next = EXEC;
      EXEC: w_next = RESP;
      RESP: if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_calc_op  <= '0;
      r_calc_a   <= '0;
      r_calc_b   <= '0;
      r_res_data <= '0;
      r_res_ovf  <= 1'b0;
      r_acc      <= '0;
      r_sticky   <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_calc_op <= cmd_op;
        r_calc_b  <= cmd_b;
        r_calc_a  <= cmd_use_acc ? r_acc : cmd_a;
      end
      if (w_exec) begin
        r_res_data <= w_v;
        r_res_ovf  <= calc_ovf;
        r_count    <= r_count + 16'd1;
      end
      // Clear takes precedence over the write-back.
      if (acc_clr) begin
        r_acc <= '0;
      end else if (w_exec) begin
        r_acc <= w_v;
      end
      // A fresh overflow outranks a same-edge clear.
      if (w_exec && calc_ovf) begin
        r_sticky <= 1'b1;
      end else if (ovf_clr) begin
        r_sticky <= 1'b0;
      end
    end
  end

  assign cmd_ready  = (r_state == IDLE);
  assign res_valid  = (r_state == RESP);
  assign calc_op    = r_calc_op;
  assign calc_a     = r_calc_a;
  assign calc_b     = r_calc_b;
  assign res_data   = r_res_data;
  assign res_ovf    = r_res_ovf;
  assign acc        = r_acc;
  assign ovf_sticky = r_sticky;
  assign op_count   = r_count;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer with a behavioural calculator model.
// Expected results are queued at issue time and checked by a monitor.
module tb_calc_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic         cmd_use_acc;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic [2:0]   calc_op;
  logic [W-1:0] calc_a;
  logic [W-1:0] calc_b;
  logic [W-1:0] calc_r;
  logic         calc_ovf;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_ovf;
  logic [W-1:0] acc;
  logic         acc_clr;
  logic         ovf_sticky;
  logic         ovf_clr;
  logic [15:0]  op_count;

  typedef struct {
    logic [15:0] data;
    logic        ovf;
    logic [15:0] acc;
    logic        sticky;
    logic [15:0] count;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] m_acc;
  logic        m_sticky;
  logic [15:0] m_count;

  calc_sequencer #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_use_acc(cmd_use_acc),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .calc_op(calc_op), .calc_a(calc_a), .calc_b(calc_b),
    .calc_r(calc_r), .calc_ovf(calc_ovf),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_ovf(res_ovf),
    .acc(acc), .acc_clr(acc_clr),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Calculator stage behaviour in plain signed integer arithmetic.
  task automatic calc_model(input logic [2:0] op, input logic [15:0] a,
                            input logic [15:0] b, output logic [15:0] r,
                            output logic o);
    int sa;
    int sb;
    int s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      3'b000:          s = sa + sb;
      3'b001:          s = sa - sb;
      3'b010, 3'b011:  s = (sb < 0) ? -sb : sb;
      3'b100:          s = sb + sa;
      3'b101:          s = sb - sa;
      default:         s = (sa < 0) ? -sa : sa;
    endcase
    r = s[15:0];
    o = (s > 32767) || (s < -32768);
  endtask

  always_comb begin
    logic [15:0] r;
    logic        o;
    calc_model(calc_op, calc_a, calc_b, r, o);
    calc_r   = r;
    calc_ovf = o;
  end

  function automatic logic [15:0] sat_val(input logic [15:0] r, input logic o);
`ifdef CALC_SEQ_SAT_EN
    if (o) return (int'($signed(r)) < 0) ? 16'h7FFF : 16'h8000;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented result is compared against the queue head.
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      if (q.size() == 0) begin
        check("unexpected_res_valid", 32'd1, 32'd0);
      end else begin
        check("res_data", res_data, q[0].data);
        check("res_ovf", res_ovf, q[0].ovf);
        check("acc", acc, q[0].acc);
        check("ovf_sticky", ovf_sticky, q[0].sticky);
        check("op_count", op_count, q[0].count);
        if (res_ready) void'(q.pop_front());
      end
    end
  end

  task automatic do_op(input logic [2:0] op, input logic use_acc,
                       input logic [15:0] a, input logic [15:0] b,
                       input int stall, input logic c0, input logic c1,
                       input logic c2, input logic junk);
    logic [15:0] ae;
    logic [15:0] r;
    logic [15:0] v;
    logic        o;
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_use_acc = use_acc;
    cmd_a       = a;
    cmd_b       = b;
    acc_clr     = c0;
    ae = use_acc ? m_acc : a;
    calc_model(op, ae, b, r, o);
    v = sat_val(r, o);
    step();
    if (c0) m_acc = '0;
    cmd_valid = junk;
    cmd_op    = 3'($urandom);
    cmd_a     = 16'($urandom);
    cmd_b     = 16'($urandom);
    acc_clr   = c1;
    ovf_clr   = c2;
    check("exec_calc_a", calc_a, ae);
    check("exec_calc_b", calc_b, b);
    check("exec_calc_op", calc_op, op);
    check("exec_res_valid", res_valid, 0);
    check("exec_cmd_ready", cmd_ready, 0);
    step();
    m_acc    = c1 ? 16'h0 : v;
    m_sticky = o | (m_sticky & ~c2);
    m_count  = m_count + 16'd1;
    q.push_back('{v, o, m_acc, m_sticky, m_count});
    acc_clr   = 1'b0;
    ovf_clr   = 1'b0;
    cmd_valid = 1'b1;
    res_ready = (stall == 0);
    check("latency_res_valid", res_valid, 1);
    for (int i = 0; i < stall; i++) begin
      step();
      check("stall_res_valid", res_valid, 1);
      check("stall_cmd_ready", cmd_ready, 0);
      check("stall_res_data", res_data, v);
    end
    res_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    check("back_idle_ready", cmd_ready, 1);
    check("back_idle_valid", res_valid, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      acc_clr = ($urandom_range(0, 3) == 0);
      ovf_clr = ($urandom_range(0, 2) == 0);
      step();
      if (acc_clr) m_acc = '0;
      if (ovf_clr) m_sticky = 1'b0;
      acc_clr = 1'b0;
      ovf_clr = 1'b0;
      check("idle_acc", acc, m_acc);
      check("idle_sticky", ovf_sticky, m_sticky);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    m_acc    = '0;
    m_sticky = 1'b0;
    m_count  = '0;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_acc", acc, 0);
    check("rst_op_count", op_count, 0);
    check("rst_calc_a", calc_a, 0);
    check("rst_calc_b", calc_b, 0);
    check("rst_calc_op", calc_op, 0);
    check("rst_res_data", res_data, 0);
    check("rst_sticky", ovf_sticky, 0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_use_acc = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    res_ready = 1'b0;
    acc_clr = 1'b0;
    ovf_clr = 1'b0;
    #1;
    do_reset();

    do_op(3'b000, 1'b0, 16'h0003, 16'h0004, 0, 0, 0, 0, 0);
    check("dir_add_data", res_data, 16'h0007);
    check("dir_add_acc", acc, 16'h0007);
    check("dir_add_count", op_count, 1);
    do_op(3'b001, 1'b1, 16'hDEAD, 16'h0002, 0, 0, 0, 0, 0);
    check("dir_sub_data", res_data, 16'h0005);
    check("dir_sub_acc", acc, 16'h0005);
    do_op(3'b000, 1'b0, 16'h7FFF, 16'h0001, 5, 0, 0, 0, 1);
`ifdef CALC_SEQ_SAT_EN
    check("dir_ovf_data", res_data, 16'h7FFF);
`else
    check("dir_ovf_data", res_data, 16'h8000);
`endif
    check("dir_ovf_flag", res_ovf, 1);
    check("dir_ovf_sticky", ovf_sticky, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    m_sticky = 1'b0;
    check("dir_ovf_clr", ovf_sticky, 0);

    // Coincident clears: acc_clr beats write-back, overflow beats ovf_clr.
    do_op(3'b101, 1'b0, 16'h7FFF, 16'h8000, 1, 0, 1, 1, 1);
    check("coinc_acc", acc, 0);
    check("coinc_sticky", ovf_sticky, 1);

    for (int t = 0; t < 60; t++) begin
      ra = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
      idle($urandom_range(0, 2));
      do_op(3'($urandom), 1'($urandom), ra, rb, $urandom_range(0, 3),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) == 0), 1'($urandom));
    end

    do_reset();
    cmd_valid = 1'b1;
    cmd_op = 3'b000;
    cmd_use_acc = 1'b0;
    cmd_a = 16'h1234;
    cmd_b = 16'h1111;
    res_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstx_cmd_ready", cmd_ready, 1);
    check("rstx_op_count", op_count, 0);
    check("rstx_acc", acc, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rstx_res_valid", res_valid, 0);
      check("rstx_count_hold", op_count, 0);
    end
    check("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
